// File: rtl/nway_sa_cache_pkg.sv
// Shared types and helpers for the set-associative cache.
// Holds the controller state type and the constant log2 used for derived widths.
package nway_sa_cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      REFILL,
      RESPOND
   } state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/nway_sa_cache_plru_tree.sv
// Combinational tree pseudo-LRU: victim selection and touch update for one set.
// Node n of the heap-ordered tree lives at bit n-1; a 0 bit points to the lower-numbered half.
module plru_tree
   import nway_sa_cache_pkg::*;
#(
   parameter int unsigned WAYS = 4,
   localparam int unsigned WAY_BITS = clog2(WAYS)
) (
   input  logic [WAYS-2:0]     plru_bits,
   input  logic                touch_en,
   input  logic [WAY_BITS-1:0] touch_way,
   output logic [WAY_BITS-1:0] victim_way,
   output logic [WAYS-2:0]     next_plru_bits
);

   logic [2*WAYS-1:0]   tree;
   logic [2*WAYS-1:0]   touched;
   logic [WAY_BITS:0]   v_node;
   logic [WAY_BITS:0]   t_node;
   logic [WAY_BITS-1:0] tw;

   always_comb begin
      tree          = '0;
      tree[WAYS-1:1] = plru_bits;
      touched       = tree;
      v_node        = (WAY_BITS+1)'(1);
      t_node        = (WAY_BITS+1)'(1);
      tw            = touch_way;
      for (int unsigned lvl = 0; lvl < WAY_BITS; lvl++) begin
         v_node = {v_node[WAY_BITS-1:0], tree[v_node]};
         // Point each node on the path at the half the touched way is not in.
         touched[t_node] = ~tw[WAY_BITS-1];
         t_node = {t_node[WAY_BITS-1:0], tw[WAY_BITS-1]};
         tw     = tw << 1;
      end
      victim_way     = v_node[WAY_BITS-1:0];
      next_plru_bits = touch_en ? touched[WAYS-1:1] : plru_bits;
   end

endmodule

// File: rtl/nway_sa_cache.sv
// N-way set-associative write-back / write-allocate cache with tree PLRU replacement.
// One CPU request in flight; misses write back a dirty victim beat by beat, then refill.
module nway_sa_cache
   import nway_sa_cache_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned WAYS          = 4,
   parameter int unsigned SETS          = 256,
   parameter int unsigned LINE_BYTES    = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_valid,
   input  logic                     cpu_we,
   input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]    cpu_wdata,
   output logic [DATA_WIDTH-1:0]    cpu_rdata,
   output logic                     cpu_ready,
   output logic                     cpu_hit,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   input  logic                     mem_ready
);

   localparam int unsigned OFFSET_BITS = clog2(LINE_BYTES);
   localparam int unsigned INDEX_BITS  = clog2(SETS);
   localparam int unsigned TAG_BITS    = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;
   localparam int unsigned BEATS       = LINE_BYTES * 8 / DATA_WIDTH;
   localparam int unsigned WORD_SHIFT  = clog2(DATA_WIDTH / 8);
   localparam int unsigned CNT_W       = (BEATS > 1) ? clog2(BEATS) : 1;
   localparam int unsigned WAY_BITS    = clog2(WAYS);

   state_t state_q, state_d;

   logic [ADDRESS_WIDTH-1:0] req_addr_q;
   logic                     req_we_q;
   logic [DATA_WIDTH-1:0]    req_wdata_q;
   logic [WAY_BITS-1:0]      vic_way_q;
   logic [TAG_BITS-1:0]      vic_tag_q;
   logic [CNT_W-1:0]         cnt_q;

   logic [WAYS-1:0]       valid_q [SETS];
   logic [WAYS-1:0]       dirty_q [SETS];
   logic [WAYS-2:0]       plru_q  [SETS];
   logic [TAG_BITS-1:0]   tag_q   [SETS][WAYS];
   logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS][BEATS];

   logic [INDEX_BITS-1:0]    req_idx;
   logic [TAG_BITS-1:0]      req_tag;
   logic [CNT_W-1:0]         req_word;
   logic [ADDRESS_WIDTH-1:0] beat_off;
   logic                     unused_low_addr;

   assign req_idx         = req_addr_q[OFFSET_BITS +: INDEX_BITS];
   assign req_tag         = req_addr_q[ADDRESS_WIDTH-1 -: TAG_BITS];
   assign req_word        = (BEATS > 1) ? req_addr_q[WORD_SHIFT +: CNT_W] : '0;
   assign beat_off        = ADDRESS_WIDTH'(cnt_q) << WORD_SHIFT;
   assign unused_low_addr = ^req_addr_q[WORD_SHIFT-1:0];

   logic                hit, inv_found, last_beat, refill_done, vic_dirty;
   logic [WAY_BITS-1:0] hit_way, inv_way, plru_victim, victim;

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!hit && valid_q[req_idx][w] && tag_q[req_idx][WAY_BITS'(w)] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_BITS'(w);
         end
         if (!inv_found && !valid_q[req_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_BITS'(w);
         end
      end
   end

   assign victim      = inv_found ? inv_way : plru_victim;
   assign vic_dirty   = valid_q[req_idx][victim] && dirty_q[req_idx][victim];
   assign last_beat   = (cnt_q == CNT_W'(BEATS - 1));
   assign refill_done = (state_q == REFILL) && mem_ready && last_beat;

   logic                  wr_en, touch_en;
   logic [WAY_BITS-1:0]   wr_way, touch_way;
   logic [CNT_W-1:0]      wr_beat;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [WAYS-2:0]       plru_next;

   plru_tree #(.WAYS(WAYS)) u_plru (
      .plru_bits      (plru_q[req_idx]),
      .touch_en       (touch_en),
      .touch_way      (touch_way),
      .victim_way     (plru_victim),
      .next_plru_bits (plru_next)
   );

   always_comb begin
      state_d   = state_q;
      cpu_ready = 1'b0;
      cpu_hit   = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      wr_en     = 1'b0;
      wr_way    = hit_way;
      wr_beat   = req_word;
      wr_data   = req_wdata_q;
      touch_en  = 1'b0;
      touch_way = hit_way;
      unique case (state_q)
         IDLE: if (cpu_valid) state_d = LOOKUP;
         LOOKUP: begin
            if (hit) begin
               cpu_ready = 1'b1;
               cpu_hit   = 1'b1;
               cpu_rdata = data_q[req_idx][hit_way][req_word];
               wr_en     = req_we_q;
               touch_en  = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = vic_dirty ? WRITEBACK : REFILL;
            end
         end
         WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {vic_tag_q, req_idx, {OFFSET_BITS{1'b0}}} | beat_off;
            mem_wdata = data_q[req_idx][vic_way_q][cnt_q];
            if (mem_ready && last_beat) state_d = REFILL;
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_idx, {OFFSET_BITS{1'b0}}} | beat_off;
            if (mem_ready) begin
               wr_en   = 1'b1;
               wr_way  = vic_way_q;
               wr_beat = cnt_q;
               wr_data = mem_rdata;
               if (last_beat) state_d = RESPOND;
            end
         end
         RESPOND: begin
            cpu_ready = 1'b1;
            cpu_rdata = data_q[req_idx][vic_way_q][req_word];
            wr_en     = req_we_q;
            wr_way    = vic_way_q;
            touch_en  = 1'b1;
            touch_way = vic_way_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         req_addr_q  <= '0;
         req_we_q    <= 1'b0;
         req_wdata_q <= '0;
         vic_way_q   <= '0;
         vic_tag_q   <= '0;
         cnt_q       <= '0;
         for (int unsigned s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && cpu_valid) begin
            req_addr_q  <= cpu_addr;
            req_we_q    <= cpu_we;
            req_wdata_q <= cpu_wdata;
         end
         if (state_q == LOOKUP && !hit) begin
            vic_way_q <= victim;
            vic_tag_q <= tag_q[req_idx][victim];
         end
         if (state_q == LOOKUP)
            cnt_q <= '0;
         else if ((state_q == WRITEBACK || state_q == REFILL) && mem_ready)
            cnt_q <= last_beat ? '0 : cnt_q + CNT_W'(1);
         if (refill_done) begin
            valid_q[req_idx][vic_way_q] <= 1'b1;
            dirty_q[req_idx][vic_way_q] <= 1'b0;
         end
         // Refill beats share the write port but must not mark the line dirty.
         if (wr_en && state_q != REFILL) dirty_q[req_idx][wr_way] <= 1'b1;
         if (touch_en) plru_q[req_idx] <= plru_next;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) data_q[req_idx][wr_way][wr_beat] <= wr_data;
      if (refill_done) tag_q[req_idx][vic_way_q] <= req_tag;
   end

endmodule
